ps2_scancode_decoder: RTL and testbench
=======================================

Name: ps2_scancode_decoder

Overview:
- Sits directly downstream of the PS/2 byte receiver.
- Consumes validated scan-code bytes (set 2) and folds E0/F0/E1 prefix sequences into single key events {extended, released, code}.
- Buffers events in a small show-ahead FIFO for the game/UI logic, which pops them at its own pace.
- Runs entirely in the system clock domain; the receiver's ready pulse arrives already synchronised to clk.

Parameters:
- DEPTH, 8, FIFO depth in events; power of two, range 2..64.
- PTR_W, $clog2(DEPTH), pointer width (derived; do not override).

Ports:
- clk  in  1  system clock; all logic on posedge.
- reset  in  1  synchronous, active-high reset.
- byte_valid  in  1  one-cycle pulse; byte_data is valid this cycle.
- byte_data  in  8  scan-code byte from the receiver.
- evt_valid  out  1  FIFO non-empty; head event is presented on evt_*.
- evt_code  out  8  head event base code (prefixes stripped).
- evt_ext  out  1  head event carried an E0 (or E1) prefix.
- evt_rel  out  1  head event is a break (F0 seen).
- evt_pop  in  1  consumer pops the head; ignored when evt_valid=0.
- overflow  out  1  sticky; an event was dropped because the FIFO was full.

Behaviour:
- Reset (synchronous, active-high): FSM=IDLE, FIFO empty, evt_valid=0, evt_code=0, evt_ext=0, evt_rel=0, overflow=0, skip counter=0.
- Reset mid-sequence discards any partial prefix; reset has priority over every other input in the same cycle.
- FSM states and transitions, all taken on byte_valid only:
  - IDLE:
    - E0 -> EXT.
    - F0 -> BRK.
    - E1 -> PAUSE with skip=7.
    - AA, FA, FE, EE, 00, FF -> IDLE, no event (BAT/ack/resend/echo/error).
    - Any other byte -> push {ext=0, rel=0, code}; stay in IDLE.
  - EXT:
    - F0 -> EXT_BRK.
    - 12 or 59 (fake shift) -> IDLE, no event.
    - Any other byte -> push {1, 0, code}; -> IDLE.
  - BRK: any byte -> push {0, 1, code}; -> IDLE.
  - EXT_BRK:
    - 12 or 59 -> IDLE, no event.
    - Any other byte -> push {1, 1, code}; -> IDLE.
  - PAUSE: each byte decrements skip. When skip reaches 0 (the 8th byte of the sequence), push {1, 0, 8'hE1}; -> IDLE. No break event is ever emitted for Pause.
- Latency:
  - A byte accepted at edge N produces an event written at edge N.
  - evt_valid rises after edge N, i.e. is visible during cycle N+1 when the FIFO was empty.
- FIFO:
  - Show-ahead; evt_* always reflect the head.
  - Pop at edge M exposes the next entry during cycle M+1, or drops evt_valid if the FIFO is now empty.
  - Full and push without pop: the event is dropped and overflow is set; it stays set until reset.
  - Full with push and pop in the same cycle: both happen, no drop.
  - Empty with push and pop in the same cycle: the pop is ignored and the push happens.
  - Pointers wrap modulo DEPTH. The occupancy counter is PTR_W+1 bits wide so that full and empty are distinct.
- byte_valid never arrives on back-to-back cycles, but the block tolerates it: each pulse is processed independently.

Optional Feature:
- SCANCODE_REPEAT_FILTER_EN, defined:
  - Keeps a 256-entry held-key bitmap indexed by {ext, code[6:0]}.
  - A make event for a key whose bit is already set (typematic repeat) is not pushed.
  - A break event clears the bit; a make event sets it.
  - The Pause event is always pushed.
  - Reset clears the bitmap.
- SCANCODE_REPEAT_FILTER_EN, undefined: every typematic make is pushed, and no bitmap is synthesised.

Decomposition:
- Package ps2_kbd_pkg holds:
  - Byte constants PS2_EXT=8'hE0, PS2_BRK=8'hF0, PS2_PAUSE=8'hE1, PS2_BAT=8'hAA, PS2_ACK=8'hFA.
  - Event width constant EVT_W=10.
  - The FSM state enum {IDLE, EXT, BRK, EXT_BRK, PAUSE}.
- One sub-module, ps2_event_fifo: the parameterised show-ahead FIFO (push/pop/full/empty/count), instantiated once.

Test Plan:
- Byte 1C -> one event {ext=0, rel=0, code=1C}; evt_valid high during the cycle after the byte pulse.
- F0,1C -> one event {0, 1, 1C}; E0,75 -> {1, 0, 75}; E0,F0,75 -> {1, 1, 75}; no events during the prefix bytes.
- Print Screen make E0,12,E0,7C -> exactly one event {1, 0, 7C}.
- Pause sequence E1,14,77,E1,F0,14,F0,77 -> exactly one event {1, 0, E1}, and the FSM is back in IDLE (verify with a following 1C -> {0, 0, 1C}).
- DEPTH=8, no pops, push 9 makes -> 8 events retained in order, overflow=1. Then a push and a pop in the same cycle while full -> no drop, count stays 8. Then reset -> evt_valid=0, overflow=0.
- With SCANCODE_REPEAT_FILTER_EN: 1C,1C,1C,F0,1C -> events {0, 0, 1C} and {0, 1, 1C} only. Without the macro -> 4 events.
- Reset asserted between E0 and 75 -> 75 afterwards yields {0, 0, 75}.

Source files
------------

// File: rtl/ps2_kbd_pkg.sv
// Shared constants, event packing and FSM state type for the PS/2 scan-code decoder.
package ps2_kbd_pkg;

  localparam logic [7:0] PS2_EXT    = 8'hE0;
  localparam logic [7:0] PS2_BRK    = 8'hF0;
  localparam logic [7:0] PS2_PAUSE  = 8'hE1;
  localparam logic [7:0] PS2_BAT    = 8'hAA;
  localparam logic [7:0] PS2_ACK    = 8'hFA;
  localparam logic [7:0] PS2_RESEND = 8'hFE;
  localparam logic [7:0] PS2_ECHO   = 8'hEE;
  localparam logic [7:0] PS2_ERR_LO = 8'h00;
  localparam logic [7:0] PS2_ERR_HI = 8'hFF;
  localparam logic [7:0] PS2_LSHIFT = 8'h12;
  localparam logic [7:0] PS2_RSHIFT = 8'h59;

  localparam int EVT_W = 10;

  typedef enum logic [2:0] {IDLE, EXT, BRK, EXT_BRK, PAUSE} state_e;

  // Controller chatter (BAT, ack, resend, echo, error) that never forms a key event.
  function automatic logic is_noise(input logic [7:0] b);
    return (b == PS2_BAT) || (b == PS2_ACK) || (b == PS2_RESEND) ||
           (b == PS2_ECHO) || (b == PS2_ERR_LO) || (b == PS2_ERR_HI);
  endfunction

  function automatic logic is_fake_shift(input logic [7:0] b);
    return (b == PS2_LSHIFT) || (b == PS2_RSHIFT);
  endfunction

  function automatic logic [EVT_W-1:0] pack_evt(input logic ext, input logic rel,
                                                input logic [7:0] code);
    return {ext, rel, code};
  endfunction

endpackage

// File: rtl/ps2_event_fifo.sv
// Show-ahead event FIFO; the head entry is visible on dout_o whenever empty_o is low.
module ps2_event_fifo
  import ps2_kbd_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int PTR_W = $clog2(DEPTH),
  parameter int W     = EVT_W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push_i,
  input  logic [W-1:0] din_i,
  input  logic         pop_i,
  output logic [W-1:0] dout_o,
  output logic         full_o,
  output logic         empty_o
);

  logic [W-1:0]   mem_q [DEPTH];
  logic [PTR_W-1:0] wr_q, rd_q;
  logic [PTR_W:0] cnt_q;
  logic           do_push_s, do_pop_s;

  assign empty_o   = (cnt_q == {(PTR_W+1){1'b0}});
  assign full_o    = (cnt_q == (PTR_W+1)'(DEPTH));
  // A pop frees the slot this same cycle, so a full FIFO still accepts a paired push.
  assign do_pop_s  = pop_i && !empty_o;
  assign do_push_s = push_i && (!full_o || do_pop_s);
  assign dout_o    = empty_o ? {W{1'b0}} : mem_q[rd_q];

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_q  <= {PTR_W{1'b0}};
      rd_q  <= {PTR_W{1'b0}};
      cnt_q <= {(PTR_W+1){1'b0}};
    end else begin
      if (do_push_s) wr_q <= wr_q + PTR_W'(1'b1);
      if (do_pop_s)  rd_q <= rd_q + PTR_W'(1'b1);
      case ({do_push_s, do_pop_s})
        2'b10:   cnt_q <= cnt_q + (PTR_W+1)'(1'b1);
        2'b01:   cnt_q <= cnt_q - (PTR_W+1)'(1'b1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // Storage write; stale contents are masked by empty_o on the output.
  always_ff @(posedge clk) begin
    if (do_push_s) mem_q[wr_q] <= din_i;
  end

endmodule

// File: rtl/ps2_scancode_decoder.sv
// Folds set-2 scan-code prefix sequences into key events buffered in a show-ahead FIFO.
// Optional SCANCODE_REPEAT_FILTER_EN suppresses typematic repeats via a held-key bitmap.
module ps2_scancode_decoder
  import ps2_kbd_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       byte_valid,
  input  logic [7:0] byte_data,
  output logic       evt_valid,
  output logic [7:0] evt_code,
  output logic       evt_ext,
  output logic       evt_rel,
  input  logic       evt_pop,
  output logic       overflow
);

  state_e     state_q, state_d;
  logic [2:0] skip_q, skip_d;
  logic       cand_s, cand_ext_s, cand_rel_s, push_s;
  logic [7:0] cand_code_s;
  logic [EVT_W-1:0] head_s;
  logic       full_s, empty_s, overflow_q;

  // Prefix state register and Pause byte counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      skip_q  <= 3'd0;
    end else begin
      state_q <= state_d;
      skip_q  <= skip_d;
    end
  end

  // Next state and candidate event; every byte_valid pulse is handled on its own.
  always_comb begin
    state_d     = state_q;
    skip_d      = skip_q;
    cand_s      = 1'b0;
    cand_ext_s  = 1'b0;
    cand_rel_s  = 1'b0;
    cand_code_s = byte_data;
    if (byte_valid) begin
      case (state_q)
        IDLE: begin
          if (byte_data == PS2_EXT) begin
            state_d = EXT;
          end else if (byte_data == PS2_BRK) begin
            state_d = BRK;
          end else if (byte_data == PS2_PAUSE) begin
            state_d = PAUSE;
            skip_d  = 3'd7;
          end else begin
            cand_s = !is_noise(byte_data);
          end
        end
        EXT: begin
          if (byte_data == PS2_BRK) begin
            state_d = EXT_BRK;
          end else begin
            state_d    = IDLE;
            cand_s     = !is_fake_shift(byte_data);
            cand_ext_s = 1'b1;
          end
        end
        BRK: begin
          state_d    = IDLE;
          cand_s     = 1'b1;
          cand_rel_s = 1'b1;
        end
        EXT_BRK: begin
          state_d    = IDLE;
          cand_s     = !is_fake_shift(byte_data);
          cand_ext_s = 1'b1;
          cand_rel_s = 1'b1;
        end
        PAUSE: begin
          skip_d = skip_q - 3'd1;
          if (skip_q == 3'd1) begin
            state_d     = IDLE;
            cand_s      = 1'b1;
            cand_ext_s  = 1'b1;
            cand_code_s = PS2_PAUSE;
          end else begin
            state_d = PAUSE;
          end
        end
        default: begin
          state_d = IDLE;
          skip_d  = 3'd0;
        end
      endcase
    end else begin
      state_d = state_q;
    end
  end

`ifdef SCANCODE_REPEAT_FILTER_EN
  logic [255:0] held_q, held_d;
  logic [7:0]   idx_s;

  assign idx_s = {cand_ext_s, cand_code_s[6:0]};

  // Make sets the held bit, break clears it; a make on a held key is swallowed. Pause bypasses.
  always_comb begin
    held_d = held_q;
    push_s = cand_s;
    if (cand_s && (state_q != PAUSE)) begin
      if (cand_rel_s) begin
        held_d[idx_s] = 1'b0;
      end else if (held_q[idx_s]) begin
        push_s = 1'b0;
      end else begin
        held_d[idx_s] = 1'b1;
      end
    end else begin
      push_s = cand_s;
    end
  end

  // Held-key bitmap register.
  always_ff @(posedge clk) begin
    if (reset) held_q <= {256{1'b0}};
    else       held_q <= held_d;
  end
`else
  assign push_s = cand_s;
`endif

  ps2_event_fifo #(.DEPTH(DEPTH), .PTR_W(PTR_W), .W(EVT_W)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (push_s),
    .din_i   (pack_evt(cand_ext_s, cand_rel_s, cand_code_s)),
    .pop_i   (evt_pop),
    .dout_o  (head_s),
    .full_o  (full_s),
    .empty_o (empty_s)
  );

  // Sticky drop flag: full, pushing, and no pop to make room.
  always_ff @(posedge clk) begin
    if (reset)                               overflow_q <= 1'b0;
    else if (push_s && full_s && !evt_pop)   overflow_q <= 1'b1;
    else                                     overflow_q <= overflow_q;
  end

  assign evt_valid = !empty_s;
  assign {evt_ext, evt_rel, evt_code} = head_s;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_ps2_scancode_decoder.sv
// Self-checking bench: directed vector table, multi-cycle corner cases, random streams vs a parser model.
module tb_ps2_scancode_decoder;

  localparam int DEPTH = 8;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       byte_valid = 1'b0;
  logic [7:0] byte_data = 8'h00;
  logic       evt_valid, evt_ext, evt_rel, overflow;
  logic [7:0] evt_code;
  logic       evt_pop = 1'b0;

  always #5 clk = ~clk;

  ps2_scancode_decoder #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .byte_valid(byte_valid), .byte_data(byte_data),
    .evt_valid(evt_valid), .evt_code(evt_code), .evt_ext(evt_ext), .evt_rel(evt_rel),
    .evt_pop(evt_pop), .overflow(overflow)
  );

  int checks = 0;
  int errors = 0;

  logic [9:0] got_q[$];
  logic [9:0] exp_q[$];
  logic [7:0] in_q[$];
  bit         held[256];
  bit         exp_ovf;

  typedef struct packed {
    logic [95:0] bytes;
    logic [3:0]  len;
    logic [2:0]  n;
    logic [39:0] evs;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; byte_valid = 1'b0; evt_pop = 1'b0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic send(input logic [7:0] b);
    @(negedge clk);
    byte_valid = 1'b1; byte_data = b;
    @(negedge clk);
    byte_valid = 1'b0;
  endtask

  task automatic drain();
    got_q.delete();
    repeat (2 * DEPTH + 4) begin
      @(negedge clk);
      evt_pop = 1'b0;
      if (evt_valid) begin
        got_q.push_back({evt_ext, evt_rel, evt_code});
        evt_pop = 1'b1;
      end
    end
    @(negedge clk);
    evt_pop = 1'b0;
    check("drained_empty", evt_valid, 0);
  endtask

  task automatic compare_events(input string nm);
    check({nm, "_count"}, got_q.size(), exp_q.size());
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      check($sformatf("%s_evt%0d", nm, i), got_q[i], exp_q[i]);
  endtask

  function automatic bit noise(input logic [7:0] b);
    return b == 8'hAA || b == 8'hFA || b == 8'hFE || b == 8'hEE || b == 8'h00 || b == 8'hFF;
  endfunction

  function automatic bit fake(input logic [7:0] b);
    return b == 8'h12 || b == 8'h59;
  endfunction

  task automatic emit(input bit ext, input bit rel, input logic [7:0] code, input bit pause);
`ifdef SCANCODE_REPEAT_FILTER_EN
    int idx;
    idx = {ext, code[6:0]};
    if (!pause) begin
      if (rel) held[idx] = 1'b0;
      else if (held[idx]) return;
      else held[idx] = 1'b1;
    end
`endif
    exp_q.push_back({ext, rel, code});
  endtask

  // Reference: walk the byte stream as a parser, then apply FIFO capacity (no pops while sending).
  task automatic run_model();
    int i, n;
    logic [7:0] b;
    exp_q.delete();
    for (int k = 0; k < 256; k++) held[k] = 1'b0;
    i = 0; n = in_q.size();
    while (i < n) begin
      b = in_q[i]; i++;
      if (b == 8'hE1) begin
        if (i + 7 <= n) emit(1'b1, 1'b0, 8'hE1, 1'b1);
        i += 7;
      end else if (b == 8'hE0) begin
        if (i >= n) break;
        b = in_q[i]; i++;
        if (b == 8'hF0) begin
          if (i >= n) break;
          b = in_q[i]; i++;
          if (!fake(b)) emit(1'b1, 1'b1, b, 1'b0);
        end else if (!fake(b)) begin
          emit(1'b1, 1'b0, b, 1'b0);
        end
      end else if (b == 8'hF0) begin
        if (i >= n) break;
        b = in_q[i]; i++;
        emit(1'b0, 1'b1, b, 1'b0);
      end else if (!noise(b)) begin
        emit(1'b0, 1'b0, b, 1'b0);
      end
    end
    exp_ovf = exp_q.size() > DEPTH;
    while (exp_q.size() > DEPTH) void'(exp_q.pop_back());
  endtask

  task automatic gen_round();
    logic [7:0] c;
    in_q.delete();
    repeat ($urandom_range(3, 9)) begin
      c = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255)) : 8'(8'h10 + $urandom_range(0, 7));
      case ($urandom_range(0, 7))
        0, 1, 2: in_q.push_back(c);
        3: begin in_q.push_back(8'hF0); in_q.push_back(c); end
        4: begin in_q.push_back(8'hE0); in_q.push_back(c); end
        5: begin in_q.push_back(8'hE0); in_q.push_back(8'hF0); in_q.push_back(c); end
        6: begin in_q.push_back(8'hE0); in_q.push_back(($urandom_range(0, 1) == 1) ? 8'h12 : 8'h59); end
        default: in_q.push_back(8'($urandom_range(0, 255)));
      endcase
    end
  endtask

  initial begin
    vecs[0] = '{96'h1C00_0000_0000_0000_0000_0000, 4'd1, 3'd1, {10'h01C, 30'h0}};
    vecs[1] = '{96'hF01C_0000_0000_0000_0000_0000, 4'd2, 3'd1, {10'h11C, 30'h0}};
    vecs[2] = '{96'hE075_0000_0000_0000_0000_0000, 4'd2, 3'd1, {10'h275, 30'h0}};
    vecs[3] = '{96'hE0F0_7500_0000_0000_0000_0000, 4'd3, 3'd1, {10'h375, 30'h0}};
    vecs[4] = '{96'hE012_E07C_0000_0000_0000_0000, 4'd4, 3'd1, {10'h27C, 30'h0}};
    vecs[5] = '{96'hE114_77E1_F014_F077_1C00_0000, 4'd9, 3'd2, {10'h2E1, 10'h01C, 20'h0}};
`ifdef SCANCODE_REPEAT_FILTER_EN
    vecs[6] = '{96'h1C1C_1CF0_1C00_0000_0000_0000, 4'd5, 3'd2, {10'h01C, 10'h11C, 20'h0}};
`else
    vecs[6] = '{96'h1C1C_1CF0_1C00_0000_0000_0000, 4'd5, 3'd4, {10'h01C, 10'h01C, 10'h01C, 10'h11C}};
`endif
    vecs[7] = '{96'hAAFA_FEEE_00FF_1C00_0000_0000, 4'd7, 3'd1, {10'h01C, 30'h0}};
    vecs[8] = '{96'hE0F0_12E0_59F0_1200_0000_0000, 4'd7, 3'd1, {10'h112, 30'h0}};

    // Reset state
    do_reset();
    check("rst_valid", evt_valid, 0);
    check("rst_code", evt_code, 0);
    check("rst_ext", evt_ext, 0);
    check("rst_rel", evt_rel, 0);
    check("rst_ovf", overflow, 0);

    // Latency: not visible before the accepting edge, visible the cycle after
    do_reset();
    @(negedge clk);
    byte_valid = 1'b1; byte_data = 8'h1C;
    check("lat_before", evt_valid, 0);
    @(negedge clk);
    byte_valid = 1'b0;
    check("lat_valid", evt_valid, 1);
    check("lat_head", {evt_ext, evt_rel, evt_code}, 10'h01C);
    drain();

    // Directed vector table
    for (int v = 0; v < 9; v++) begin
      do_reset();
      for (int j = 0; j < int'(vecs[v].len); j++) send(vecs[v].bytes[95 - 8*j -: 8]);
      drain();
      exp_q.delete();
      for (int j = 0; j < int'(vecs[v].n); j++) exp_q.push_back(vecs[v].evs[39 - 10*j -: 10]);
      compare_events($sformatf("vec%0d", v));
    end

    // Overflow, then simultaneous push+pop while full, then reset
    do_reset();
    for (int k = 0; k < 9; k++) send(8'(8'h15 + k));
    check("ovf_set", overflow, 1);
    check("ovf_head", evt_code, 8'h15);
    @(negedge clk);
    byte_valid = 1'b1; byte_data = 8'h2A; evt_pop = 1'b1;
    @(negedge clk);
    byte_valid = 1'b0; evt_pop = 1'b0;
    check("full_pp_head", evt_code, 8'h16);
    check("full_pp_ovf", overflow, 1);
    drain();
    exp_q.delete();
    for (int k = 0; k < 7; k++) exp_q.push_back({2'b00, 8'(8'h16 + k)});
    exp_q.push_back(10'h02A);
    compare_events("full_pp");
    do_reset();
    check("ovf_rst_valid", evt_valid, 0);
    check("ovf_rst_ovf", overflow, 0);

    // Empty with push and pop together: pop ignored
    do_reset();
    @(negedge clk);
    byte_valid = 1'b1; byte_data = 8'h33; evt_pop = 1'b1;
    @(negedge clk);
    byte_valid = 1'b0; evt_pop = 1'b0;
    check("empty_pp_valid", evt_valid, 1);
    check("empty_pp_head", {evt_ext, evt_rel, evt_code}, 10'h033);
    drain();
    check("empty_pp_count", got_q.size(), 1);

    // Reset between E0 and 75 drops the prefix
    do_reset();
    send(8'hE0);
    do_reset();
    send(8'h75);
    drain();
    exp_q.delete(); exp_q.push_back(10'h075);
    compare_events("rst_mid");

    // Back-to-back byte pulses
    do_reset();
    @(negedge clk);
    byte_valid = 1'b1; byte_data = 8'hF0;
    @(negedge clk);
    byte_data = 8'h2B;
    @(negedge clk);
    byte_valid = 1'b0;
    drain();
    exp_q.delete(); exp_q.push_back(10'h12B);
    compare_events("b2b");

    // Random streams against the parser model
    for (int r = 0; r < 30; r++) begin
      do_reset();
      gen_round();
      foreach (in_q[k]) send(in_q[k]);
      run_model();
      check($sformatf("rnd%0d_ovf", r), overflow, exp_ovf);
      drain();
      compare_events($sformatf("rnd%0d", r));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
